// File: rtl/string_match_pkg.sv
// Shared types and constants for the string match controller.
package string_match_pkg;

    localparam int MAX_STRLEN = 17;

    typedef logic [0:MAX_STRLEN-1][7:0] flag_string_t;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        STREAM,
        DRAIN,
        REPORT
    } state_t;

endpackage

// File: rtl/string_match_drain_timer.sv
// Loadable down-counter; o_done is high while the count sits at zero.
module string_match_drain_timer #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         n_rst,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_en,
    output logic         o_done
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_en && (r_cnt != '0)) begin
            r_cnt <= r_cnt - W'(1);
        end
    end

    assign o_done = (r_cnt == '0);

endmodule

// File: rtl/string_match_controller.sv
// Sequences one string comparator over packet payloads and reports a verdict.
// Optional MATCH_STATS_EN adds a saturating matched-packet counter.
module string_match_controller
    import string_match_pkg::*;
#(
    parameter int DRAIN_CYCLES = 6,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             cfg_wr,
    input  flag_string_t     cfg_string,
    input  logic [4:0]       cfg_strlen,
    output logic             cfg_busy,
    input  logic             pkt_start,
    input  logic             pkt_valid,
    input  logic [31:0]      pkt_data,
    input  logic             pkt_end,
    output logic             pkt_ready,
    output logic             cmp_clear,
    output logic [31:0]      cmp_data_in,
    output flag_string_t     cmp_flagged_string,
    output logic [4:0]       cmp_strlen,
    input  logic             cmp_match,
    output logic             result_valid,
    output logic             result_match,
    output logic [CNT_W-1:0] result_words,
    input  logic             result_ack
`ifdef MATCH_STATS_EN
    ,
    input  logic             stats_clr,
    output logic [15:0]      match_count
`endif
);

    localparam int TW = $clog2(DRAIN_CYCLES) + 1;

    state_t           r_state;
    state_t           w_next;
    flag_string_t     r_string;
    logic [4:0]       r_strlen;
    logic             r_match;
    logic [CNT_W-1:0] r_words;
    logic             r_post;
    logic             w_accept;
    logic             w_last;
    logic             w_drain_done;
    logic             w_ack;
    logic [4:0]       w_clamped;

    assign w_accept  = (r_state == STREAM) && pkt_valid;
    assign w_last    = w_accept && pkt_end;
    assign w_ack     = (r_state == REPORT) && result_ack;
    assign w_clamped = (cfg_strlen > 5'(MAX_STRLEN)) ? 5'(MAX_STRLEN) : cfg_strlen;

    string_match_drain_timer #(.W(TW)) u_drain (
        .clk        (clk),
        .n_rst      (n_rst),
        .i_load     (w_last),
        .i_load_val (TW'(DRAIN_CYCLES - 1)),
        .i_en       (r_state == DRAIN),
        .o_done     (w_drain_done)
    );

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:    if (pkt_start) w_next = CLEAR;
            CLEAR:   w_next = r_post ? IDLE : STREAM;
            STREAM:  if (w_last) w_next = DRAIN;
            DRAIN:   if (w_drain_done) w_next = REPORT;
            REPORT:  if (result_ack) w_next = CLEAR;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_string <= '0;
            r_strlen <= '0;
            r_match  <= 1'b0;
            r_words  <= '0;
            r_post   <= 1'b0;
        end else begin
            if ((r_state == IDLE) && cfg_wr) begin
                r_string <= cfg_string;
                r_strlen <= w_clamped;
            end
            if (r_state == CLEAR) begin
                r_match <= 1'b0;
                r_words <= '0;
                r_post  <= 1'b0;
            end
            // A zero-length string can never be a real match.
            if ((r_state == STREAM) || (r_state == DRAIN)) begin
                r_match <= (r_strlen != '0) && (r_match || cmp_match);
            end
            if (w_accept && (r_words != '1)) begin
                r_words <= r_words + CNT_W'(1);
            end
            if (w_ack) begin
                r_post <= 1'b1;
            end
        end
    end

    assign cfg_busy           = (r_state != IDLE);
    assign pkt_ready          = (r_state == STREAM);
    assign cmp_clear          = (r_state == CLEAR);
    assign cmp_data_in        = w_accept ? pkt_data : 32'h0;
    assign cmp_flagged_string = r_string;
    assign cmp_strlen         = r_strlen;
    assign result_valid       = (r_state == REPORT);
    assign result_match       = r_match;
    assign result_words       = r_words;

`ifdef MATCH_STATS_EN
    logic [15:0] r_match_count;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_match_count <= '0;
        end else if (stats_clr) begin
            r_match_count <= '0;
        end else if (w_ack && r_match && (r_match_count != '1)) begin
            r_match_count <= r_match_count + 16'd1;
        end
    end

    assign match_count = r_match_count;
`endif

endmodule

// File: tb/tb_string_match_controller.sv
// Directed self-checking bench for string_match_controller.
module tb_string_match_controller;
    import string_match_pkg::*;

    logic             clk = 1'b0;
    logic             n_rst = 1'b0;
    logic             cfg_wr = 1'b0;
    flag_string_t     cfg_string = '0;
    logic [4:0]       cfg_strlen = '0;
    logic             cfg_busy;
    logic             pkt_start = 1'b0;
    logic             pkt_valid = 1'b0;
    logic [31:0]      pkt_data = '0;
    logic             pkt_end = 1'b0;
    logic             pkt_ready;
    logic             cmp_clear;
    logic [31:0]      cmp_data_in;
    flag_string_t     cmp_flagged_string;
    logic [4:0]       cmp_strlen;
    logic             cmp_match = 1'b0;
    logic             result_valid;
    logic             result_match;
    logic [15:0]      result_words;
    logic             result_ack = 1'b0;
`ifdef MATCH_STATS_EN
    logic             stats_clr = 1'b0;
    logic [15:0]      match_count;
`endif

    int n_assert = 0;
    int n_fail = 0;
    int lat;
    flag_string_t goog;

    string_match_controller #(.DRAIN_CYCLES(6), .CNT_W(16)) dut (
        .clk                (clk),
        .n_rst              (n_rst),
        .cfg_wr             (cfg_wr),
        .cfg_string         (cfg_string),
        .cfg_strlen         (cfg_strlen),
        .cfg_busy           (cfg_busy),
        .pkt_start          (pkt_start),
        .pkt_valid          (pkt_valid),
        .pkt_data           (pkt_data),
        .pkt_end            (pkt_end),
        .pkt_ready          (pkt_ready),
        .cmp_clear          (cmp_clear),
        .cmp_data_in        (cmp_data_in),
        .cmp_flagged_string (cmp_flagged_string),
        .cmp_strlen         (cmp_strlen),
        .cmp_match          (cmp_match),
        .result_valid       (result_valid),
        .result_match       (result_match),
        .result_words       (result_words),
        .result_ack         (result_ack)
`ifdef MATCH_STATS_EN
        ,
        .stats_clr          (stats_clr),
        .match_count        (match_count)
`endif
    );

    always #5 clk = ~clk;

    function automatic flag_string_t mk(input string s);
        flag_string_t f;
        f = '0;
        for (int i = 0; i < s.len() && i < MAX_STRLEN; i++) f[i] = s[i];
        return f;
    endfunction

    task automatic chk(input string tag, input logic [135:0] obs,
                       input logic [135:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cfg(input string s, input logic [4:0] len);
        @(negedge clk);
        cfg_wr = 1'b1;
        cfg_string = mk(s);
        cfg_strlen = len;
        @(negedge clk);
        cfg_wr = 1'b0;
        #1;
    endtask

    task automatic start_pkt();
        @(negedge clk);
        pkt_start = 1'b1;
        @(negedge clk);
        pkt_start = 1'b0;
        #1;
        chk("start_clear", cmp_clear, 1);
        chk("start_data0", cmp_data_in, 0);
    endtask

    task automatic send_word(input logic [31:0] w, input bit last,
                             input bit m);
        @(negedge clk);
        pkt_valid = 1'b1;
        pkt_data = w;
        pkt_end = last;
        cmp_match = m;
        #1;
        chk("fwd_data", cmp_data_in, w);
    endtask

    task automatic gap(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            pkt_valid = 1'b0;
            pkt_data = 32'hDEADBEEF;
            #1;
            chk("gap_data0", cmp_data_in, 0);
        end
    endtask

    task automatic wait_result(input bit pulse, input bit all_on,
                               output int l);
        l = 99;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            pkt_valid = 1'b0;
            pkt_end = 1'b0;
            pkt_data = 32'h12345678;
            cmp_match = all_on || (pulse && k == 3);
            #1;
            if (k == 1) chk("drain_data0", cmp_data_in, 0);
            if (result_valid) begin
                l = k;
                break;
            end
        end
        cmp_match = 1'b0;
    endtask

    task automatic finish_pkt(input bit m, input int words, input int hold,
                              input bit ps);
        chk("res_match", result_match, m);
        chk("res_words", result_words, words);
        for (int k = 0; k < hold; k++) begin
            @(negedge clk);
            pkt_start = ps;
            #1;
            chk("hold_valid", result_valid, 1);
            chk("hold_words", result_words, words);
            chk("hold_match", result_match, m);
        end
        @(negedge clk);
        result_ack = 1'b1;
        pkt_start = 1'b0;
        @(negedge clk);
        result_ack = 1'b0;
        #1;
        chk("ack_clear", cmp_clear, 1);
        chk("ack_valid0", result_valid, 0);
        @(negedge clk);
        #1;
        chk("idle_busy0", cfg_busy, 0);
    endtask

    initial begin
        goog = mk("www.google.com");
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("rst_busy", cfg_busy, 0);
        chk("rst_valid", result_valid, 0);
        chk("rst_strlen", cmp_strlen, 0);
        chk("rst_string", cmp_flagged_string, 0);
        n_rst = 1'b1;

        // Config load and a matched packet
        cfg("www.google.com", 5'd14);
        chk("cfg_strlen", cmp_strlen, 14);
        chk("cfg_string", cmp_flagged_string, goog);
        start_pkt();
        send_word("www.", 1'b0, 1'b0);
        chk("stream_ready", pkt_ready, 1);
        send_word("goog", 1'b0, 1'b0);
        send_word("le.c", 1'b0, 1'b0);
        send_word("om  ", 1'b1, 1'b0);
        wait_result(1'b1, 1'b0, lat);
        chk("match_latency", lat, 7);
        finish_pkt(1'b1, 4, 0, 1'b0);

        // No match
        start_pkt();
        send_word("www.", 1'b0, 1'b0);
        send_word("goog", 1'b0, 1'b0);
        send_word("book", 1'b0, 1'b0);
        send_word(".com", 1'b1, 1'b0);
        wait_result(1'b0, 1'b0, lat);
        chk("nomatch_latency", lat, 7);
        finish_pkt(1'b0, 4, 0, 1'b0);

        // Gapped input
        start_pkt();
        send_word("www.", 1'b0, 1'b0);
        send_word("goog", 1'b0, 1'b0);
        gap(3);
        send_word("le.c", 1'b0, 1'b0);
        send_word("om  ", 1'b1, 1'b0);
        wait_result(1'b1, 1'b0, lat);
        chk("gap_latency", lat, 7);
        finish_pkt(1'b1, 4, 0, 1'b0);

        // Busy protection
        start_pkt();
        send_word("www.", 1'b0, 1'b0);
        @(negedge clk);
        pkt_valid = 1'b0;
        cfg_wr = 1'b1;
        cfg_string = mk("abc");
        cfg_strlen = 5'd3;
        #1;
        chk("busy_high", cfg_busy, 1);
        @(negedge clk);
        cfg_wr = 1'b0;
        #1;
        chk("busy_strlen", cmp_strlen, 14);
        chk("busy_string", cmp_flagged_string, goog);
        send_word("goog", 1'b1, 1'b0);
        wait_result(1'b0, 1'b0, lat);
        chk("busy_latency", lat, 7);
        finish_pkt(1'b0, 2, 5, 1'b1);

        // Clamp and zero length
        cfg("www.google.com", 5'd25);
        chk("clamp_strlen", cmp_strlen, 17);
        cfg("www.google.com", 5'd0);
        chk("zero_strlen", cmp_strlen, 0);
        start_pkt();
        send_word("www.", 1'b0, 1'b1);
        send_word("goog", 1'b1, 1'b1);
        wait_result(1'b0, 1'b1, lat);
        chk("zero_latency", lat, 7);
        finish_pkt(1'b0, 2, 0, 1'b0);

        // Reset in the middle of DRAIN
        cfg("www.google.com", 5'd14);
        start_pkt();
        send_word("www.", 1'b1, 1'b0);
        @(negedge clk);
        pkt_valid = 1'b0;
        pkt_end = 1'b0;
        @(negedge clk);
        #1;
        chk("pre_rst_busy", cfg_busy, 1);
        n_rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("mid_rst_busy", cfg_busy, 0);
        chk("mid_rst_clear", cmp_clear, 0);
        chk("mid_rst_strlen", cmp_strlen, 0);
        chk("mid_rst_string", cmp_flagged_string, 0);
        chk("mid_rst_words", result_words, 0);
        n_rst = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            #1;
            chk("post_rst_valid", result_valid, 0);
        end
        chk("post_rst_busy", cfg_busy, 0);

`ifdef MATCH_STATS_EN
        chk("stats_rst", match_count, 0);
        cfg("www.google.com", 5'd14);
        for (int p = 0; p < 2; p++) begin
            start_pkt();
            send_word("www.", 1'b1, 1'b0);
            wait_result(1'b1, 1'b0, lat);
            chk("stats_latency", lat, 7);
            finish_pkt(1'b1, 1, 0, 1'b0);
        end
        chk("stats_two", match_count, 2);
        @(negedge clk);
        stats_clr = 1'b1;
        @(negedge clk);
        stats_clr = 1'b0;
        #1;
        chk("stats_clr", match_count, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/string_match_controller.md
Name: string_match_controller

Overview:
Sequences one string comparator instance over packet payloads. Holds the active flagged string and length, and issues the comparator clear between packets. Forwards payload words, flushes the comparator pipeline with zero words, and reports one sticky match verdict per packet over a valid/ack handshake. Sits between the payload extractor and the comparator in the sniffer datapath.

Parameters:
MAX_STRLEN, 17, bytes in the flagged string register; cfg_strlen is clamped to this value.
DRAIN_CYCLES, 6, zero words fed after pkt_end to flush the comparator pipeline.
CNT_W, 16, width of the payload word counter (saturating).

Ports:
clk  input  1  system clock
n_rst  input  1  asynchronous active-low reset
cfg_wr  input  1  load cfg_string/cfg_strlen (honoured only in IDLE)
cfg_string  input  [0:MAX_STRLEN-1][7:0]  flagged string, byte 0 first
cfg_strlen  input  5  flagged string length in bytes
cfg_busy  output  1  high when state is not IDLE
pkt_start  input  1  start of packet (sampled only in IDLE)
pkt_valid  input  1  pkt_data is valid this cycle
pkt_data  input  32  payload word, first byte in [31:24]
pkt_end  input  1  last payload word (qualified by pkt_valid)
pkt_ready  output  1  controller accepts payload (STREAM only)
cmp_clear  output  1  comparator clear pulse
cmp_data_in  output  32  word to comparator
cmp_flagged_string  output  [0:MAX_STRLEN-1][7:0]  registered flagged string
cmp_strlen  output  5  registered, clamped length
cmp_match  input  1  comparator match flag
result_valid  output  1  verdict available
result_match  output  1  sticky match for the packet
result_words  output  CNT_W  payload words accepted for the packet
result_ack  input  1  consumer accepts verdict

Behaviour:
- Reset, async: state IDLE; string register all 0; strlen 0; all outputs 0; counters 0. Reset mid-packet aborts with no result.
- IDLE: cfg_wr loads the string register and min(cfg_strlen, MAX_STRLEN) next edge. pkt_start moves to CLEAR. If cfg_wr and pkt_start arrive together, the cfg load completes and the state moves to CLEAR.
- CLEAR: 1 cycle; cmp_clear=1, cmp_data_in=0, sticky match and word counter zeroed; then STREAM.
- STREAM: pkt_ready=1. When pkt_valid, cmp_data_in=pkt_data and word counter increments (saturates at all ones). Otherwise cmp_data_in=0. pkt_valid&pkt_end moves to DRAIN.
- DRAIN: cmp_data_in=0 for exactly DRAIN_CYCLES cycles (down-counter), then REPORT.
- Sticky match: OR of cmp_match sampled in every STREAM and DRAIN cycle. If strlen==0, the sticky match is forced 0.
- REPORT: result_valid=1. result_match and result_words are held stable until result_ack, and remain stable while valid is high. result_ack seen, then CLEAR (1-cycle cmp_clear), then IDLE. Ack in the same cycle valid first rises is legal.
- Ignored inputs: pkt_start outside IDLE; cfg_wr outside IDLE (cfg_busy=1); pkt_valid outside STREAM.
- Latency: pkt_end accepted → result_valid rises DRAIN_CYCLES+1 cycles later.
- cmp_flagged_string and cmp_strlen are direct register outputs and do not change during a packet.

Optional Feature:
MATCH_STATS_EN.
- Defined: adds output match_count [15:0], a saturating count of packets reported with result_match=1, incremented on the result_ack handshake. Adds input stats_clr, which zeroes the count; if stats_clr and the increment coincide, clear wins. Count is 0 on reset.
- Undefined: neither port exists and no counter logic is built.

Decomposition:
- Package string_match_pkg holds:
  - state enum {IDLE, CLEAR, STREAM, DRAIN, REPORT};
  - MAX_STRLEN;
  - typedef flag_string_t = logic [0:MAX_STRLEN-1][7:0].
- Natural sub-module: string_match_drain_timer, a loadable down-counter asserting done at zero. FSM and sticky logic stay in the top.

Test Plan:
- Config load and single match: cfg "www.google.com", len 14, in IDLE; packet "www.","goog","le.c","om  " with stub match pulse during DRAIN. Required: result_valid 7 cycles after pkt_end, result_match=1, result_words=4, cmp_clear pulses at start and after ack.
- No match: same config; packet "www.","goog","book",".com". Required: result_match=0, result_words=4.
- Gapped input: pkt_valid low 3 cycles mid-packet. Required: cmp_data_in=0 during the gaps, result_words counts only valid words, latency unchanged.
- Busy protection: cfg_wr with "abc" during STREAM, and pkt_start during REPORT. Required: cfg_busy=1, string register unchanged, no second packet started; result held stable for 5 cycles until ack.
- Clamp and zero length: cfg_strlen=25 gives cmp_strlen=17. cfg_strlen=0 with cmp_match forced 1 gives result_match=0.
- Reset mid-DRAIN: n_rst low for 2 cycles. Required: IDLE, all outputs 0, no result_valid. With MATCH_STATS_EN, match_count=0 after reset, 2 after two matched acks, 0 after stats_clr.
